// File: rtl/param_tensor_core.sv
// N x N signed matrix multiply (optionally accumulate) core producing one
// output element per clock from N parallel multipliers and an adder tree.
module param_tensor_core #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                                        clock_in,
  input  logic                                        reset_n_in,
  input  logic                                        start_in,
  input  logic                                        mode_in,
  input  logic signed [N-1:0][N-1:0][DATA_WIDTH-1:0]  matrix_a_in,
  input  logic signed [N-1:0][N-1:0][DATA_WIDTH-1:0]  matrix_b_in,
  input  logic signed [N-1:0][N-1:0][DATA_WIDTH-1:0]  matrix_c_in,
  output logic signed [N-1:0][N-1:0][DATA_WIDTH-1:0]  result_out,
  output logic                                        busy_out,
  output logic                                        done_out,
  output logic                                        result_valid_out
);

  localparam int IDXW = $clog2(N * N) + 1;
  localparam int RW   = $clog2(N);

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N * N - 1);
  localparam logic [RW-1:0]   POS_LAST = RW'(N - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef logic signed [N-1:0][N-1:0][DATA_WIDTH-1:0] mat_t;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [RW-1:0]         row_q, row_d;
  logic [RW-1:0]         col_q, col_d;
  logic                  valid_q, valid_d;
  logic                  mode_q;
  mat_t                  a_q, b_q, c_q, result_q;
  logic                  capture;
  logic                  write_en;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [DATA_WIDTH-1:0]        elem;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{(ACC_WIDTH - DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    valid_d  = valid_q;
    capture  = 1'b0;
    write_en = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_in) begin
          state_d = COMPUTE;
          capture = 1'b1;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          valid_d = 1'b0;
        end
      end
      COMPUTE: begin
        write_en = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDXW'(1);
          if (col_q == POS_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Dot product of the current row of A with the current column of B.
  always_comb begin
    acc = mode_q ? sext(c_q[row_q][col_q]) : '0;
    for (int k = 0; k < N; k++) begin
      acc = acc + sext(a_q[row_q][RW'(k)]) * sext(b_q[RW'(k)][col_q]);
    end
    elem = acc[DATA_WIDTH-1:0];
    if (SATURATE) begin
      if (acc > SAT_MAX) begin
        elem = SAT_MAX[DATA_WIDTH-1:0];
      end else if (acc < SAT_MIN) begin
        elem = SAT_MIN[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      if (capture) begin
        a_q    <= matrix_a_in;
        b_q    <= matrix_b_in;
        c_q    <= matrix_c_in;
        mode_q <= mode_in;
      end
      if (write_en) begin
        result_q[row_q][col_q] <= elem;
      end
    end
  end

  assign busy_out         = (state_q == COMPUTE);
  assign done_out         = (state_q == DONE);
  assign result_valid_out = valid_q;
  assign result_out       = result_q;

endmodule

// File: tb/tb_param_tensor_core.sv
// Directed and randomized checks of param_tensor_core (saturating and wrapping
// instances side by side) against a plain-arithmetic matrix model.
module tb_param_tensor_core;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 20;

  typedef logic signed [N-1:0][N-1:0][DW-1:0] mat_t;

  logic clk   = 1'b0;
  logic rstN  = 1'b0;
  logic start = 1'b0;
  logic mode  = 1'b0;
  mat_t matA  = '0;
  mat_t matB  = '0;
  mat_t matC  = '0;
  mat_t resSat, resWrap;
  logic busySat, doneSat, validSat;
  logic busyWrap, doneWrap, validWrap;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycleCount  = 0;
  mat_t expSat, expWrap;

  param_tensor_core #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1'b1)) dutSat (
    .clock_in(clk), .reset_n_in(rstN), .start_in(start), .mode_in(mode),
    .matrix_a_in(matA), .matrix_b_in(matB), .matrix_c_in(matC),
    .result_out(resSat), .busy_out(busySat), .done_out(doneSat),
    .result_valid_out(validSat)
  );

  param_tensor_core #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1'b0)) dutWrap (
    .clock_in(clk), .reset_n_in(rstN), .start_in(start), .mode_in(mode),
    .matrix_a_in(matA), .matrix_b_in(matB), .matrix_c_in(matC),
    .result_out(resWrap), .busy_out(busyWrap), .done_out(doneWrap),
    .result_valid_out(validWrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Reference: textbook matrix product with integer arithmetic, then clamp or wrap.
  function automatic mat_t model(input mat_t a, input mat_t b, input mat_t c,
                                 input logic md, input logic sat);
    mat_t d;
    int   s;
    int   hi = (1 << (DW - 1)) - 1;
    int   lo = -(1 << (DW - 1));
    for (int r = 0; r < N; r++) begin
      for (int cc = 0; cc < N; cc++) begin
        s = md ? int'($signed(c[r][cc])) : 0;
        for (int k = 0; k < N; k++) begin
          s += int'($signed(a[r][k])) * int'($signed(b[k][cc]));
        end
        if (sat) begin
          if (s > hi) s = hi;
          else if (s < lo) s = lo;
        end
        d[r][cc] = DW'(s);
      end
    end
    return d;
  endfunction

  function automatic mat_t fillMat(input int v);
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int cc = 0; cc < N; cc++)
        m[r][cc] = DW'(v);
    return m;
  endfunction

  function automatic mat_t randMat();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int cc = 0; cc < N; cc++)
        m[r][cc] = DW'($urandom);
    return m;
  endfunction

  task automatic checkOutput(input string tag, input mat_t obs, input mat_t exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkValue(input string tag, input int obs, input int exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic applyStimulus(input string tag, input mat_t a, input mat_t b,
                               input mat_t c, input logic md);
    expSat  = model(a, b, c, md, 1'b1);
    expWrap = model(a, b, c, md, 1'b0);
    matA  = a;
    matB  = b;
    matC  = c;
    mode  = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkValue({tag, " busy after start"}, int'(busySat && busyWrap), 1);
    checkValue({tag, " valid cleared at start"}, int'(validSat || validWrap), 0);
  endtask

  task automatic waitDone(input string tag, input int busyStartAt, output int doneAt);
    int doneM      = -1;
    int busyDrops  = 0;
    mat_t holdSat  = expSat;
    mat_t holdWrap = expWrap;
    doneAt = -1;
    for (int m = 1; m <= 64; m++) begin
      if (m == busyStartAt) begin
        matA  = '0;
        matB  = '0;
        matC  = '0;
        start = 1'b1;
      end
      if (m == busyStartAt + 1) start = 1'b0;
      @(negedge clk);
      if (doneSat) begin
        doneM  = m;
        doneAt = cycleCount;
        break;
      end
      if (!busySat || !busyWrap) busyDrops++;
    end
    start = 1'b0;
    checkValue({tag, " done latency"}, doneM, N * N);
    checkValue({tag, " busy held while computing"}, busyDrops, 0);
    checkValue({tag, " done on both"}, int'(doneWrap), 1);
    checkValue({tag, " busy low in done"}, int'(busySat || busyWrap), 0);
    checkValue({tag, " valid in done"}, int'(validSat && validWrap), 1);
    checkOutput({tag, " result sat"}, resSat, holdSat);
    checkOutput({tag, " result wrap"}, resWrap, holdWrap);
  endtask

  task automatic checkDoneCleared(input string tag);
    @(negedge clk);
    checkValue({tag, " done single pulse"}, int'(doneSat || doneWrap), 0);
    checkValue({tag, " idle no restart"}, int'(busySat || busyWrap), 0);
    checkValue({tag, " valid held"}, int'(validSat && validWrap), 1);
  endtask

  initial begin
    mat_t a, b;
    int   d1, d2, pulses;

    #12;
    checkOutput("reset result sat", resSat, '0);
    checkOutput("reset result wrap", resWrap, '0);
    checkValue("reset flags", int'({busySat, doneSat, validSat, busyWrap, doneWrap, validWrap}), 0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    for (int r = 0; r < N; r++)
      for (int cc = 0; cc < N; cc++) begin
        a[r][cc] = (r == cc) ? DW'(1) : DW'(0);
        b[r][cc] = DW'(N * r + cc);
      end
    applyStimulus("identity", a, b, '0, 1'b0);
    waitDone("identity", -1, d1);
    checkOutput("identity equals B", resSat, b);
    checkDoneCleared("identity");

    applyStimulus("mma", fillMat(1), fillMat(2), fillMat(3), 1'b1);
    waitDone("mma", -1, d1);
    checkOutput("mma all 11", resSat, fillMat(11));
    checkDoneCleared("mma");

    applyStimulus("sat pos", fillMat(127), fillMat(127), fillMat(5), 1'b0);
    waitDone("sat pos", -1, d1);
    checkOutput("sat pos clamp", resSat, fillMat(127));
    checkOutput("sat pos wrap", resWrap, fillMat(4));
    checkDoneCleared("sat pos");

    applyStimulus("sat neg", fillMat(-128), fillMat(127), '0, 1'b0);
    waitDone("sat neg", -1, d1);
    checkOutput("sat neg clamp", resSat, fillMat(-128));
    checkDoneCleared("sat neg");

    applyStimulus("isolation", randMat(), randMat(), randMat(), 1'b1);
    waitDone("isolation", 5, d1);
    checkDoneCleared("isolation");

    applyStimulus("reset mid", randMat(), randMat(), randMat(), 1'b1);
    for (int m = 1; m <= 8; m++) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("reset mid result sat", resSat, '0);
    checkOutput("reset mid result wrap", resWrap, '0);
    checkValue("reset mid flags", int'({busySat, doneSat, validSat, busyWrap, doneWrap, validWrap}), 0);
    @(negedge clk);
    rstN = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (doneSat || doneWrap || busySat) pulses++;
    end
    checkValue("reset mid no done", pulses, 0);
    applyStimulus("after reset", randMat(), randMat(), randMat(), 1'b0);
    waitDone("after reset", -1, d1);
    checkDoneCleared("after reset");

    applyStimulus("b2b first", randMat(), randMat(), randMat(), 1'b1);
    waitDone("b2b first", -1, d1);
    applyStimulus("b2b second", randMat(), randMat(), randMat(), 1'b0);
    waitDone("b2b second", -1, d2);
    checkValue("b2b done spacing", d2 - d1, N * N + 1);
    checkDoneCleared("b2b second");

    for (int j = 0; j < 4; j++) begin
      applyStimulus("random", randMat(), randMat(), randMat(), 1'($urandom));
      waitDone("random", -1, d1);
      checkDoneCleared("random");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
